// File: rtl/rsq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rsq_pkg: shared entry/match types and the CDB priority-match helper        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rsq_pkg;

  // Entry fields are sized to the largest supported configuration.
  // Instances zero-extend into them and slice their own widths back out.
  localparam int MAX_OP_W   = 8;
  localparam int MAX_TAG_W  = 8;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_CDB    = 4;
  localparam int CDB_IDX_W  = $clog2(MAX_CDB);

  localparam logic [MAX_TAG_W-1:0] TAG_READY = '0;

  typedef struct packed {
    logic [MAX_OP_W-1:0]   op;
    logic [MAX_TAG_W-1:0]  tag_a;
    logic [MAX_DATA_W-1:0] data_a;
    logic [MAX_TAG_W-1:0]  tag_b;
    logic [MAX_DATA_W-1:0] data_b;
    logic [MAX_TAG_W-1:0]  id;
  } rsq_entry_t;

  typedef struct packed {
    logic                  hit;
    logic [CDB_IDX_W-1:0]  idx;
    logic [MAX_DATA_W-1:0] data;
  } cdb_hit_t;

  typedef logic [MAX_CDB-1:0][MAX_TAG_W-1:0]  cdb_tags_t;
  typedef logic [MAX_CDB-1:0][MAX_DATA_W-1:0] cdb_datas_t;

  // Scans from the top channel down so the lowest matching index wins.
  function automatic cdb_hit_t cdb_match(
    input logic [MAX_TAG_W-1:0] tag,
    input logic [MAX_CDB-1:0]   vld,
    input cdb_tags_t            tags,
    input cdb_datas_t           datas
  );
    cdb_hit_t r;
    r = '0;
    if (tag != TAG_READY) begin
      for (int k = MAX_CDB - 1; k >= 0; k--) begin
        if (vld[k] && (tags[k] == tag)) begin
          r.hit  = 1'b1;
          r.idx  = CDB_IDX_W'(k);
          r.data = datas[k];
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsq_id_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rsq_id_alloc: free-mask result-ID allocator with lowest-free priority      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rsq_id_alloc #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5,
  parameter int ID_BASE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_id,
  output logic [TAG_W-1:0] alloc_id
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mask;
  logic [DEPTH-1:0] w_mask_nxt;
  logic [IDX_W-1:0] w_low_idx;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_alloc_idx;
  logic             w_full;

  assign w_full     = &r_mask;
  assign w_free_idx = IDX_W'(free_id - TAG_W'(ID_BASE));

  always_comb begin
    w_low_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_mask[i]) w_low_idx = IDX_W'(i);
    end
  end

  // A full mask has no free bit, so the ID leaving this cycle is handed straight on.
  assign w_alloc_idx = (w_full && free_en) ? w_free_idx : w_low_idx;
  assign alloc_id    = TAG_W'(ID_BASE) + TAG_W'(w_alloc_idx);

  always_comb begin
    w_mask_nxt = r_mask;
    if (free_en)  w_mask_nxt[w_free_idx]  = 1'b0;
    if (alloc_en) w_mask_nxt[w_alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_mask <= '0;
    else if (flush) r_mask <= '0;
    else            r_mask <= w_mask_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/rsq_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rsq_issue_queue: in-order two-operand reservation queue with CDB snooping  |
// | Option: RSQ_ENQ_BYPASS_EN captures same-cycle broadcasts at enqueue.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rsq_issue_queue
  import rsq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int OP_W    = 2,
  parameter int NUM_CDB = 2,
  parameter int ID_BASE = 1
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_op,
  input  logic [TAG_W-1:0]          in_tag_a,
  input  logic [TAG_W-1:0]          in_tag_b,
  input  logic [DATA_W-1:0]         in_data_a,
  input  logic [DATA_W-1:0]         in_data_b,
  output logic [TAG_W-1:0]          alloc_id,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           out_op,
  output logic [DATA_W-1:0]         out_data_a,
  output logic [DATA_W-1:0]         out_data_b,
  output logic [TAG_W-1:0]          out_id,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rsq_entry_t       r_q [DEPTH];
  rsq_entry_t       w_q_nxt [DEPTH];
  rsq_entry_t       w_head;
  rsq_entry_t       w_new;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] w_occ;
  cdb_hit_t         w_hit_a [DEPTH];
  cdb_hit_t         w_hit_b [DEPTH];
  logic [MAX_CDB-1:0] w_cdb_vld;
  cdb_tags_t        w_cdb_tags;
  cdb_datas_t       w_cdb_datas;
  logic             w_out_valid;
  logic             w_fire;
  logic             w_enq;
  logic [TAG_W-1:0] w_alloc_id;

  always_comb begin
    w_cdb_vld   = '0;
    w_cdb_tags  = '0;
    w_cdb_datas = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      w_cdb_vld[k]   = cdb_valid[k];
      w_cdb_tags[k]  = MAX_TAG_W'(cdb_tag[k*TAG_W +: TAG_W]);
      w_cdb_datas[k] = MAX_DATA_W'(cdb_data[k*DATA_W +: DATA_W]);
    end
  end

  assign w_head      = r_q[r_head];
  assign w_out_valid = (r_count != '0) && (w_head.tag_a == TAG_READY) && (w_head.tag_b == TAG_READY);
  assign w_fire      = w_out_valid && out_ready;
  assign in_ready    = (r_count < CNT_W'(DEPTH)) || w_fire;
  assign w_enq       = in_valid && in_ready;

  rsq_id_alloc #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .ID_BASE (ID_BASE)
  ) u_id_alloc (
    .clk      (clk),
    .rst      (RST),
    .flush    (flush),
    .alloc_en (w_enq),
    .free_en  (w_fire),
    .free_id  (w_head.id[TAG_W-1:0]),
    .alloc_id (w_alloc_id)
  );

  // Slot occupancy is measured from the head, so free slots never snoop.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    localparam logic [PTR_W-1:0] SLOT = PTR_W'(gi);
    logic [PTR_W-1:0] w_rel;
    assign w_rel       = SLOT - r_head;
    assign w_occ[gi]   = {1'b0, w_rel} < r_count;
    assign w_hit_a[gi] = cdb_match(r_q[gi].tag_a, w_cdb_vld, w_cdb_tags, w_cdb_datas);
    assign w_hit_b[gi] = cdb_match(r_q[gi].tag_b, w_cdb_vld, w_cdb_tags, w_cdb_datas);
  end

`ifdef RSQ_ENQ_BYPASS_EN
  cdb_hit_t w_byp_a;
  cdb_hit_t w_byp_b;
  assign w_byp_a = cdb_match(MAX_TAG_W'(in_tag_a), w_cdb_vld, w_cdb_tags, w_cdb_datas);
  assign w_byp_b = cdb_match(MAX_TAG_W'(in_tag_b), w_cdb_vld, w_cdb_tags, w_cdb_datas);
`endif

  always_comb begin
    w_new        = '0;
    w_new.op     = MAX_OP_W'(in_op);
    w_new.tag_a  = MAX_TAG_W'(in_tag_a);
    w_new.data_a = MAX_DATA_W'(in_data_a);
    w_new.tag_b  = MAX_TAG_W'(in_tag_b);
    w_new.data_b = MAX_DATA_W'(in_data_b);
    w_new.id     = MAX_TAG_W'(w_alloc_id);
`ifdef RSQ_ENQ_BYPASS_EN
    if (w_byp_a.hit) begin
      w_new.tag_a  = TAG_READY;
      w_new.data_a = w_byp_a.data;
    end
    if (w_byp_b.hit) begin
      w_new.tag_b  = TAG_READY;
      w_new.data_b = w_byp_b.data;
    end
`endif
  end

  // Later writes win: an issuing head is zeroed, then a full-queue enqueue reuses the slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_q_nxt[i] = r_q[i];
      if (w_occ[i] && w_hit_a[i].hit) begin
        w_q_nxt[i].tag_a  = TAG_READY;
        w_q_nxt[i].data_a = w_hit_a[i].data;
      end
      if (w_occ[i] && w_hit_b[i].hit) begin
        w_q_nxt[i].tag_b  = TAG_READY;
        w_q_nxt[i].data_b = w_hit_b[i].data;
      end
    end
    if (w_fire) w_q_nxt[r_head] = '0;
    if (w_enq)  w_q_nxt[r_tail] = w_new;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      r_q     <= w_q_nxt;
      r_head  <= r_head + PTR_W'(w_fire);
      r_tail  <= r_tail + PTR_W'(w_enq);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_fire);
    end
  end

  assign out_valid  = w_out_valid;
  assign out_op     = w_head.op[OP_W-1:0];
  assign out_data_a = w_head.data_a[DATA_W-1:0];
  assign out_data_b = w_head.data_b[DATA_W-1:0];
  assign out_id     = w_head.id[TAG_W-1:0];
  assign alloc_id   = w_alloc_id;
  assign count      = r_count;

endmodule
`default_nettype wire
